// File: rtl/tri_scheduler.sv
// Triangle dispatcher: FIFO-buffers triangles, presents them one at a time to the
// rasterizer, and swaps front/back frame-buffer bases at vsync after a frame's last triangle.
//
// state     | meaning
// S_IDLE    | waiting for a queued triangle; pops the head when one is present
// S_ISSUE   | current triangle presented (rast_valid=1) until the rasterizer fetches
// S_WAIT    | frame's last triangle retired; waiting for vsync to swap buffers
module tri_scheduler #(
  parameter int          DEPTH    = 4,
  parameter logic [25:0] FB_BASE0 = 26'h0000000,
  parameter logic [25:0] FB_BASE1 = 26'h004B000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         tri_valid_i,
  output logic         tri_ready_o,
  input  logic [191:0] tri_xy_i,
  input  logic [71:0]  tri_color_i,
  input  logic         tri_last_i,
  output logic         rast_valid_o,
  output logic [191:0] rast_xy_o,
  output logic [71:0]  rast_color_o,
  output logic [25:0]  rast_addr_o,
  output logic         rast_done_o,
  input  logic         rast_fetch_i,
  input  logic         vsync_i,
  output logic [25:0]  fb_front_o,
  output logic         frame_done_o,
  output logic [15:0]  frame_count_o,
  output logic         busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [191:0] xy_mem_q    [DEPTH];
  logic [71:0]  color_mem_q [DEPTH];
  logic         last_mem_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [191:0]  rast_xy_q, rast_xy_d;
  logic [71:0]   rast_color_q, rast_color_d;
  logic          rast_done_q, rast_done_d;
  logic          sel_q, sel_d;
  logic [25:0]   fb_front_q, fb_front_d, rast_addr_q, rast_addr_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          push, pop, swap;

  assign tri_ready_o = (count_q != CW'(DEPTH));
  assign push        = tri_valid_i && tri_ready_o;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign swap        = (state_q == S_WAIT) && vsync_i;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_ISSUE;
      S_ISSUE: if (rast_fetch_i) state_d = rast_done_q ? S_WAIT : S_IDLE;
      S_WAIT:  if (vsync_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rast_xy_d    = pop ? xy_mem_q[rd_ptr_q]    : rast_xy_q;
    rast_color_d = pop ? color_mem_q[rd_ptr_q] : rast_color_q;
    rast_done_d  = pop ? last_mem_q[rd_ptr_q]  : rast_done_q;

    // Back buffer is always the base the display is not scanning.
    sel_d         = swap ? ~sel_q : sel_q;
    fb_front_d    = sel_d ? FB_BASE1 : FB_BASE0;
    rast_addr_d   = sel_d ? FB_BASE0 : FB_BASE1;
    frame_done_d  = swap;
    frame_count_d = frame_count_q + {15'd0, swap};
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      xy_mem_q[wr_ptr_q]    <= tri_xy_i;
      color_mem_q[wr_ptr_q] <= tri_color_i;
      last_mem_q[wr_ptr_q]  <= tri_last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      rast_xy_q     <= '0;
      rast_color_q  <= '0;
      rast_done_q   <= 1'b0;
      sel_q         <= 1'b0;
      fb_front_q    <= FB_BASE0;
      rast_addr_q   <= FB_BASE1;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      rast_xy_q     <= rast_xy_d;
      rast_color_q  <= rast_color_d;
      rast_done_q   <= rast_done_d;
      sel_q         <= sel_d;
      fb_front_q    <= fb_front_d;
      rast_addr_q   <= rast_addr_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign rast_valid_o  = (state_q == S_ISSUE);
  assign rast_xy_o     = rast_xy_q;
  assign rast_color_o  = rast_color_q;
  assign rast_done_o   = rast_done_q;
  assign rast_addr_o   = rast_addr_q;
  assign fb_front_o    = fb_front_q;
  assign frame_done_o  = frame_done_q;
  assign frame_count_o = frame_count_q;
  assign busy_o        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_tri_scheduler.sv
// Bench for tri_scheduler: queue-based reference model compared every cycle,
// plus directed literal checks and randomized traffic.
module tb_tri_scheduler;
  localparam int          DEPTH = 4;
  localparam logic [25:0] B0 = 26'h0000000;
  localparam logic [25:0] B1 = 26'h004B000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tri_valid = 1'b0, tri_last = 1'b0, rast_fetch = 1'b0, vsync = 1'b0;
  logic [191:0] tri_xy = '0;
  logic [71:0]  tri_color = '0;
  logic         tri_ready, rast_valid, rast_done, frame_done, busy;
  logic [191:0] rast_xy;
  logic [71:0]  rast_color;
  logic [25:0]  rast_addr, fb_front;
  logic [15:0]  frame_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  tri_scheduler #(.DEPTH(DEPTH), .FB_BASE0(B0), .FB_BASE1(B1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tri_valid_i(tri_valid), .tri_ready_o(tri_ready),
    .tri_xy_i(tri_xy), .tri_color_i(tri_color), .tri_last_i(tri_last),
    .rast_valid_o(rast_valid), .rast_xy_o(rast_xy), .rast_color_o(rast_color),
    .rast_addr_o(rast_addr), .rast_done_o(rast_done), .rast_fetch_i(rast_fetch),
    .vsync_i(vsync), .fb_front_o(fb_front), .frame_done_o(frame_done),
    .frame_count_o(frame_count), .busy_o(busy)
  );

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of waiting triangles, the one being presented,
  // and whether a finished frame is waiting on vsync.
  typedef struct packed {
    logic [191:0] xy;
    logic [71:0]  col;
    logic         last;
  } tri_t;

  tri_t        mq[$];
  tri_t        m_cur = '0;
  bit          m_have = 0, m_wait = 0, m_sel = 0, m_done = 0;
  logic [15:0] m_cnt = '0;
  bit          push_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_cur = '0; m_have = 0; m_wait = 0; m_sel = 0; m_done = 0; m_cnt = '0;
    end else begin
      push_ok = tri_valid && (mq.size() < DEPTH);
      m_done  = 0;
      if (!m_have && !m_wait && mq.size() > 0) begin
        m_cur  = mq.pop_front();
        m_have = 1;
      end else if (m_have && rast_fetch) begin
        m_have = 0;
        if (m_cur.last) m_wait = 1;
      end else if (m_wait && vsync) begin
        m_wait = 0;
        m_sel  = ~m_sel;
        m_cnt  = m_cnt + 16'd1;
        m_done = 1;
      end
      if (push_ok) mq.push_back('{xy: tri_xy, col: tri_color, last: tri_last});
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && chk_en) begin
      chk("m_tri_ready", 192'(tri_ready), 192'(mq.size() != DEPTH));
      chk("m_rast_valid", 192'(rast_valid), 192'(m_have));
      chk("m_rast_xy", rast_xy, m_cur.xy);
      chk("m_rast_color", 192'(rast_color), 192'(m_cur.col));
      chk("m_rast_done", 192'(rast_done), 192'(m_cur.last));
      chk("m_fb_front", 192'(fb_front), 192'(m_sel ? B1 : B0));
      chk("m_rast_addr", 192'(rast_addr), 192'(m_sel ? B0 : B1));
      chk("m_frame_done", 192'(frame_done), 192'(m_done));
      chk("m_frame_count", 192'(frame_count), 192'(m_cnt));
      chk("m_busy", 192'(busy), 192'(m_have || m_wait || mq.size() > 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!rast_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rast_valid) begin
      errors++;
      $display("FAIL %s timeout actual=0 required=1", nm);
    end
  endtask

  logic [191:0] t1_xy;
  bit           low_ok;
  bit           sel_before;

  initial begin
    t1_xy = {32'd20, 32'd10, 32'd10, 32'd20, 32'd10, 32'd10};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 192'(tri_ready), 192'(1));
    chk("reset_front", 192'(fb_front), 192'(26'h0));
    chk("reset_addr", 192'(rast_addr), 192'(26'h004B000));
    rst_n = 1'b1;
    cyc();

    // Single triangle frame
    tri_valid = 1; tri_xy = t1_xy; tri_color = 72'hFF0000_00FF00_0000FF; tri_last = 1;
    cyc();
    tri_valid = 0; tri_last = 0;
    @(negedge clk);
    chk("single_valid_n", 192'(rast_valid), 192'(0));
    chk("single_busy_n", 192'(busy), 192'(1));
    cyc();
    @(negedge clk);
    chk("single_valid_n1", 192'(rast_valid), 192'(1));
    chk("single_xy", rast_xy, t1_xy);
    chk("single_done", 192'(rast_done), 192'(1));
    repeat (10) cyc();
    rast_fetch = 1; vsync = 1;
    cyc();
    rast_fetch = 0; vsync = 0;
    @(negedge clk);
    chk("single_fetch_valid", 192'(rast_valid), 192'(0));
    chk("single_vsync_ignored", 192'(frame_count), 192'(0));
    repeat (3) cyc();
    vsync = 1;
    cyc();
    vsync = 0;
    @(negedge clk);
    chk("swap_front", 192'(fb_front), 192'(26'h004B000));
    chk("swap_addr", 192'(rast_addr), 192'(26'h0));
    chk("swap_pulse", 192'(frame_done), 192'(1));
    chk("swap_count", 192'(frame_count), 192'(1));
    cyc();
    @(negedge clk);
    chk("swap_pulse_end", 192'(frame_done), 192'(0));
    chk("idle_busy", 192'(busy), 192'(0));

    // Backpressure: five pushes with no fetch
    for (int k = 0; k < 5; k++) begin
      tri_valid = 1; tri_xy = {160'd0, 32'(100 + k)};
      cyc();
    end
    tri_valid = 0;
    @(negedge clk);
    chk("bp_full", 192'(tri_ready), 192'(0));
    for (int k = 0; k < 5; k++) begin
      wait_valid("bp_wait");
      chk("bp_order", 192'(rast_xy[31:0]), 192'(100 + k));
      cyc();
      rast_fetch = 1;
      cyc();
      rast_fetch = 0;
    end

    // Frame boundary: B must wait for the swap
    tri_valid = 1; tri_xy = {160'd0, 32'd200}; tri_last = 1;
    cyc();
    tri_xy = {160'd0, 32'd201}; tri_last = 0;
    cyc();
    tri_valid = 0;
    wait_valid("fb_a_wait");
    chk("fb_a_xy", 192'(rast_xy[31:0]), 192'(200));
    cyc();
    rast_fetch = 1;
    cyc();
    rast_fetch = 0;
    low_ok = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rast_valid) low_ok = 0;
    end
    chk("fb_hold_low", 192'(low_ok), 192'(1));
    cyc();
    vsync = 1;
    cyc();
    vsync = 0;
    wait_valid("fb_b_wait");
    chk("fb_b_xy", 192'(rast_xy[31:0]), 192'(201));
    chk("fb_b_addr", 192'(rast_addr), 192'(B1));
    chk("fb_b_count", 192'(frame_count), 192'(2));
    cyc();
    rast_fetch = 1;
    cyc();
    rast_fetch = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tri_valid  = ($urandom % 2) == 0;
      tri_xy     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tri_color  = {$urandom, $urandom, $urandom};
      tri_last   = ($urandom % 6) == 0;
      rast_fetch = ($urandom % 3) == 0;
      vsync      = ($urandom % 4) == 0;
      cyc();
    end

    // Drain, then force the counter to its wrap point
    tri_valid = 0; rast_fetch = 1; vsync = 1;
    repeat (20) cyc();
    @(negedge clk);
    chk("drain_busy", 192'(busy), 192'(0));
    chk_en = 0;
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    chk_en = 1;
    chk("wrap_preload", 192'(frame_count), 192'(16'hFFFF));
    sel_before = m_sel;
    #1;
    tri_valid = 1; tri_xy = '1; tri_last = 1;
    cyc();
    tri_valid = 0; tri_last = 0;
    begin
      int n = 0;
      @(negedge clk);
      while (!frame_done && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("wrap_pulse", 192'(frame_done), 192'(1));
    chk("wrap_count", 192'(frame_count), 192'(0));
    chk("wrap_front", 192'(fb_front), 192'(sel_before ? B0 : B1));
    rast_fetch = 0; vsync = 0;

    // Asynchronous reset while a triangle is being presented
    cyc();
    tri_valid = 1; tri_xy = t1_xy; tri_last = 0;
    cyc();
    tri_valid = 1; tri_xy = '1;
    cyc();
    tri_valid = 0;
    wait_valid("rst_wait");
    chk("rst_pre_valid", 192'(rast_valid), 192'(1));
    cyc();
    rst_n = 0;
    #1;
    chk("rst_valid", 192'(rast_valid), 192'(0));
    chk("rst_xy", rast_xy, 192'(0));
    chk("rst_color", 192'(rast_color), 192'(0));
    chk("rst_done", 192'(rast_done), 192'(0));
    chk("rst_ready", 192'(tri_ready), 192'(1));
    chk("rst_front", 192'(fb_front), 192'(26'h0000000));
    chk("rst_addr", 192'(rast_addr), 192'(26'h004B000));
    chk("rst_fdone", 192'(frame_done), 192'(0));
    chk("rst_count", 192'(frame_count), 192'(0));
    chk("rst_busy", 192'(busy), 192'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) cyc();
    @(negedge clk);
    chk("post_rst_idle", 192'(rast_valid), 192'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
